// File: rtl/seq_divider32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations per divide.
// Latency WIDTH cycles from accept to done (1 for zero divisor); start is ignored while busy.
module seq_divider32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // S_ZERO is a non-busy settling cycle so a zero divisor reports done one edge after accept.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_next;

    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Partial remainder kept WIDTH+1 bits wide: rem can have its MSB set when dsr is large.
    assign trial    = {rem_q, dvd_q[WIDTH-1]};
    assign qbit     = (trial >= {1'b0, dsr_q});
    assign rem_next = qbit ? WIDTH'(trial - {1'b0, dsr_q}) : trial[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? S_ZERO : S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_ZERO:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_comb begin
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        remo_d = remo_q;
        dbz_d  = dbz_q;
        if (accept) begin
            cnt_d = '0;
            dvd_d = dividend;
            dsr_d = divisor;
            rem_d = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = cnt_q + CW'(1);
            dvd_d = {dvd_q[WIDTH-2:0], qbit};
            rem_d = rem_next;
            if (last_iter) begin
                quo_d  = {dvd_q[WIDTH-2:0], qbit};
                remo_d = rem_next;
                dbz_d  = 1'b0;
            end
        end else if (state_q == S_ZERO) begin
            quo_d  = '1;
            remo_d = dvd_q;
            dbz_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            remo_q <= '0;
            dbz_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            remo_q <= remo_d;
            dbz_q  <= dbz_d;
        end
    end

    assign quotient    = quo_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Directed bench for seq_divider32: fixed vectors, back-to-back, ignored start, reset abort, random pairs.
module tb_seq_divider32;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_cmp;
    int n_bad;

    seq_divider32 #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Counts edges (continuing from n0) until done is seen; budget-bounded.
    task automatic wait_done(input int n0, output int n, output logic saw_busy);
        n = n0;
        saw_busy = 1'b0;
        while (!done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) saw_busy = 1'b1;
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic eb, input int elat);
        int   lat;
        logic sb;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (b != 0)});
        wait_done(0, lat, sb);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, eb});
        if (b == 0) chk({tag, "_nobusy"}, {31'd0, sb}, 32'd0);
    endtask

    initial begin
        int          lat;
        logic        sb;
        logic [31:0] a, b;
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("t1",    32'd100,      32'd7,        32'd14,       32'd2,    1'b0, 32);
        do_op("t2a",   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,    1'b0, 32);
        do_op("t2b",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,    1'b0, 32);
        do_op("t2c",   32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFE, 1'b0, 32);
        do_op("t3a",   32'd5,        32'd9,        32'd0,        32'd5,    1'b0, 32);
        do_op("t3b",   32'd0,        32'd3,        32'd0,        32'd0,    1'b0, 32);
        do_op("t4",    32'd1234,     32'd0,        32'hFFFFFFFF, 32'd1234, 1'b1, 1);
        do_op("t4clr", 32'd81,       32'd9,        32'd9,        32'd0,    1'b0, 32);

        // Start pulsed mid-run must be ignored; start held in the DONE cycle is accepted.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        @(posedge clk);
        #1;
        lat++;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        wait_done(lat, lat, sb);
        chk("t5_lat", lat, 32);
        chk("t5_q", quotient, 32'd14);
        chk("t5_r", remainder, 32'd2);
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("t5b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(0, lat, sb);
        chk("t5b2b_lat", lat, 32);
        chk("t5b2b_q", quotient, 32'd4);
        chk("t5b2b_r", remainder, 32'd1);

        // Reset mid-run aborts immediately.
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_done", {31'd0, done}, 32'd0);
        chk("t6_q", quotient, 32'd0);
        chk("t6_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("t6_nodone", {31'd0, done}, 32'd0);
        do_op("t6post", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 32);

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (i % 25 == 0) b = 32'd0;
            if (b == 0) do_op("rnd", a, b, 32'hFFFFFFFF, a, 1'b1, 1);
            else        do_op("rnd", a, b, a / b, a % b, 1'b0, 32);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
